ptcalc_round_sat: RTL

PTCALC_ROUND_SAT -- requirements
Module: ptcalc_round_sat

---
 rtl/ptcalc_pkg.sv | 9 +
 rtl/ptcalc_round_sat_core.sv | 42 ++++
 rtl/ptcalc_round_sat.sv | 112 +++++++++++
 3 files changed

// File: rtl/ptcalc_pkg.sv
// Shared defaults for the product round/saturate stage.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package ptcalc_pkg;
  localparam int PTCALC_PROD_W = 39;
  localparam int PTCALC_SHIFT  = 14;
  localparam int PTCALC_OUT_W  = 16;
  localparam int PTCALC_CNT_W  = 16;
endpackage

// File: rtl/ptcalc_round_sat_core.sv
// Rounds a signed product (half toward +inf) and clips it to OUT_WIDTH signed.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing pipeline owns all flow control.
module ptcalc_round_sat_core #(
  parameter int PROD_WIDTH = 39,
  parameter int SHIFT      = 14,
  parameter int OUT_WIDTH  = 16
) (
  input  logic [PROD_WIDTH-1:0] in_prod,
  output logic [OUT_WIDTH-1:0]  data,
  output logic                  sat
);

  // Width of the value left after the fractional bits are dropped.
  localparam int SW = PROD_WIDTH + 1 - SHIFT;
  localparam logic [PROD_WIDTH:0] RND = {{PROD_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [PROD_WIDTH:0]    sum;
  logic signed [SW-1:0]   shifted;
  logic                   unused_frac;

  // One extra bit keeps the rounding add from overflowing; taking the upper
  // slice is the arithmetic shift, and the dropped fraction is discarded.
  always_comb begin
    sum     = {in_prod[PROD_WIDTH-1], in_prod} + RND;
    shifted = $signed(sum[PROD_WIDTH:SHIFT]);
    data    = shifted[OUT_WIDTH-1:0];
    sat     = 1'b0;
    if (shifted > MAXV) begin
      data = MAXV[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end else if (shifted < MINV) begin
      data = MINV[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end
  end

  assign unused_frac = ^sum[SHIFT-1:0];

endmodule

// File: rtl/ptcalc_round_sat.sv
// Two-stage round/saturate pipeline with optional saturation counter (PTCALC_ROUND_SAT_CNT_EN).
// Latency: 2 cycles input transfer to out_valid; one result per cycle at full rate.
// Backpressure: global enable, in_ready = !out_valid || out_ready; all stages hold when stalled.
module ptcalc_round_sat
  import ptcalc_pkg::*;
#(
  parameter int PROD_WIDTH = PTCALC_PROD_W,
  parameter int SHIFT      = PTCALC_SHIFT,
  parameter int OUT_WIDTH  = PTCALC_OUT_W
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PROD_WIDTH-1:0]   in_prod,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_sat,
  input  logic                    clr_cnt,
  output logic [PTCALC_CNT_W-1:0] sat_cnt
);

  logic                  pipe_en;
  logic                  s1_vld_d, s1_vld_q;
  logic [PROD_WIDTH-1:0] s1_prod_d, s1_prod_q;
  logic                  out_vld_d, out_vld_q;
  logic [OUT_WIDTH-1:0]  out_data_d, out_data_q;
  logic                  out_sat_d, out_sat_q;
  logic [OUT_WIDTH-1:0]  core_data;
  logic                  core_sat;

  ptcalc_round_sat_core #(
    .PROD_WIDTH (PROD_WIDTH),
    .SHIFT      (SHIFT),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_core (
    .in_prod (s1_prod_q),
    .data    (core_data),
    .sat     (core_sat)
  );

  assign in_ready  = pipe_en;
  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Next-state for both stages: advance together (bubbles included) or hold.
  always_comb begin
    pipe_en    = !out_vld_q || out_ready;
    s1_vld_d   = s1_vld_q;
    s1_prod_d  = s1_prod_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (pipe_en) begin
      s1_vld_d   = in_valid;
      s1_prod_d  = in_prod;
      out_vld_d  = s1_vld_q;
      out_data_d = core_data;
      out_sat_d  = core_sat;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_prod_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_prod_q  <= s1_prod_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

`ifdef PTCALC_ROUND_SAT_CNT_EN
  logic [PTCALC_CNT_W-1:0] sat_cnt_d, sat_cnt_q;

  // Count saturated results actually taken downstream; sticks at all-ones, clear wins.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clr_cnt) begin
      sat_cnt_d = '0;
    end else if (out_vld_q && out_ready && out_sat_q && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  // Saturation counter register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_clr;

  assign unused_clr = clr_cnt;
  assign sat_cnt    = '0;
`endif

endmodule
